vga_sync_gen: RTL and testbench

//  Video timing source that drives the pixel-coordinate interface consumed by the game graphics blocks.

---
 rtl/vga_sync_gen_pkg.sv | 34 +++
 rtl/vga_sync_gen_pix_tick_div.sv | 34 +++
 rtl/vga_sync_gen.sv | 113 +++++++++++
 tb/tb_vga_sync_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing defaults (640x480@60) and decode helpers for the sync generator and the
// graph/text generators. Optional frame counter port: VGA_SYNC_FRAME_CNT_EN.
package vga_sync_gen_pkg;

   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL      = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL      = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int DEF_HSYNC_START  = DEF_H_DISPLAY + DEF_H_FRONT;
   localparam int DEF_HSYNC_END    = DEF_HSYNC_START + DEF_H_SYNC - 1;
   localparam int DEF_VSYNC_START  = DEF_V_DISPLAY + DEF_V_FRONT;
   localparam int DEF_VSYNC_END    = DEF_VSYNC_START + DEF_V_SYNC - 1;
   localparam int DEF_REFRESH_LINE = DEF_V_DISPLAY + 1;

   typedef struct packed {
      logic hsync;
      logic vsync;
   } sync_t;

   // Inclusive window test on a 10-bit counter value.
   function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick_div.sv
// pix_tick_div: modulo-CLK_DIV counter producing a one-clk pixel enable.
// With CLK_DIV=1 the counter stays at zero and p_tick is constantly high.
module pix_tick_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

   logic [W-1:0] div_reg;
   logic [W-1:0] div_next;

   always_comb begin
      div_next = div_reg + W'(1);
      if (div_reg == DIV_LAST) begin
         div_next = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg <= '0;
      end else begin
         div_reg <= div_next;
      end
   end

   assign p_tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel/line counters, registered sync decode, video_on and refresh pulse.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit completed-frame counter output.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int   CLK_DIV   = DEF_CLK_DIV,
   parameter int   H_DISPLAY = DEF_H_DISPLAY,
   parameter int   H_FRONT   = DEF_H_FRONT,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BACK    = DEF_H_BACK,
   parameter int   V_DISPLAY = DEF_V_DISPLAY,
   parameter int   V_FRONT   = DEF_V_FRONT,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BACK    = DEF_V_BACK,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        p_tick,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] HSYNC_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HSYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VSYNC_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VSYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] X_VISIBLE   = 10'(H_DISPLAY);
   localparam logic [9:0] Y_VISIBLE   = 10'(V_DISPLAY);
   localparam logic [9:0] REFRESH_Y   = 10'(V_DISPLAY + 1);

   logic [9:0] x_reg, x_next;
   logic [9:0] y_reg, y_next;
   sync_t      sync_reg, sync_next;
   logic       frame_end;

   pix_tick_div #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .p_tick(p_tick)
   );

   assign frame_end = p_tick && (x_reg == H_LAST) && (y_reg == V_LAST);

   // Sync is decoded from the next counter values so the registered outputs line up with pix_x/pix_y.
   always_comb begin
      x_next = x_reg;
      y_next = y_reg;
      if (p_tick) begin
         if (x_reg == H_LAST) begin
            x_next = '0;
            y_next = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
         end else begin
            x_next = x_reg + 10'd1;
         end
      end
      sync_next.hsync = in_window(x_next, HSYNC_START, HSYNC_END) ? SYNC_POL : ~SYNC_POL;
      sync_next.vsync = in_window(y_next, VSYNC_START, VSYNC_END) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_reg          <= '0;
         y_reg          <= '0;
         sync_reg.hsync <= ~SYNC_POL;
         sync_reg.vsync <= ~SYNC_POL;
      end else begin
         x_reg    <= x_next;
         y_reg    <= y_next;
         sync_reg <= sync_next;
      end
   end

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [15:0] frame_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_reg <= '0;
      end else if (frame_end) begin
         frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_reg;
`else
   logic unused_frame_end;
   assign unused_frame_end = frame_end;
`endif

   assign pix_x      = x_reg;
   assign pix_y      = y_reg;
   assign hsync      = sync_reg.hsync;
   assign vsync      = sync_reg.vsync;
   assign video_on   = (x_reg < X_VISIBLE) && (y_reg < Y_VISIBLE);
   assign frame_tick = p_tick && (x_reg == 10'd0) && (y_reg == REFRESH_Y);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken instance (fast full frames)
// checked every clk against an arithmetic model driven by clks elapsed since reset release.
module tb_vga_sync_gen;

   localparam int S_D  = 3;
   localparam int S_HD = 16, S_HF = 4, S_HS = 6, S_HB = 6;
   localparam int S_VD = 12, S_VF = 2, S_VS = 2, S_VB = 3;
   localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

   logic clk = 1'b0;
   logic reset;

   logic       p_tick_d, hsync_d, vsync_d, video_on_d, frame_tick_d;
   logic [9:0] pix_x_d, pix_y_d;
   logic       p_tick_s, hsync_s, vsync_s, video_on_s, frame_tick_s;
   logic [9:0] pix_x_s, pix_y_s;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [15:0] frame_cnt_d, frame_cnt_s;
`endif

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .clk       (clk),
      .reset     (reset),
      .p_tick    (p_tick_d),
      .pix_x     (pix_x_d),
      .pix_y     (pix_y_d),
      .hsync     (hsync_d),
      .vsync     (vsync_d),
      .video_on  (video_on_d),
      .frame_tick(frame_tick_d)
`ifdef VGA_SYNC_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt_d)
`endif
   );

   vga_sync_gen #(
      .CLK_DIV(S_D), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_POL(1'b1)
   ) dut_s (
      .clk       (clk),
      .reset     (reset),
      .p_tick    (p_tick_s),
      .pix_x     (pix_x_s),
      .pix_y     (pix_y_s),
      .hsync     (hsync_s),
      .vsync     (vsync_s),
      .video_on  (video_on_s),
      .frame_tick(frame_tick_s)
`ifdef VGA_SYNC_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt_s)
`endif
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   longint      k        = 0;     // clk edges counted since reset release
   logic [15:0] fc_off   = '0;
   bit          line_valid, frame_valid;
   int          hs_cnt, hs_first, ft_cnt;

   // Expected {p_tick,hsync,vsync,video_on,frame_tick,x,y} after k clks, straight from the timing rules.
   function automatic logic [24:0] model(longint kk, int d, int hd, int hf, int hs, int hb,
                                         int vd, int vf, int vs, int vb, bit pol);
      longint ht, vt, p, x, y;
      bit pt, hact, vact, hsy, vsy, von, ft;
      ht   = hd + hf + hs + hb;
      vt   = vd + vf + vs + vb;
      p    = (kk / d) % (ht * vt);
      x    = p % ht;
      y    = p / ht;
      pt   = (kk % d) == d - 1;
      hact = (x >= hd + hf) && (x < hd + hf + hs);
      vact = (y >= vd + vf) && (y < vd + vf + vs);
      hsy  = hact ? pol : !pol;
      vsy  = vact ? pol : !pol;
      von  = (x < hd) && (y < vd);
      ft   = pt && (x == 0) && (y == vd + 1);
      return {pt, hsy, vsy, von, ft, 10'(x), 10'(y)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h k=%0d", tag, obs, exp, k);
   endtask

   task automatic sample();
      logic [24:0] od, os;
      od = {p_tick_d, hsync_d, vsync_d, video_on_d, frame_tick_d, pix_x_d, pix_y_d};
      os = {p_tick_s, hsync_s, vsync_s, video_on_s, frame_tick_s, pix_x_s, pix_y_s};
      chk("default_outputs", 64'(od), 64'(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
      chk("small_outputs", 64'(os),
          64'(model(k, S_D, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1)));
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("default_frame_cnt", 64'(frame_cnt_d), 64'(16'((k / 2) / 420000)));
      chk("small_frame_cnt", 64'(frame_cnt_s), 64'(16'(fc_off + 16'((k / S_D) / (S_HT * S_VT)))));
`endif
      // hsync pulse width and start position, measured over whole default-timing lines
      if (p_tick_d) begin
         if (pix_x_d == 10'd0) begin
            line_valid = 1'b1;
            hs_cnt     = 0;
            hs_first   = -1;
         end
         if (hsync_d == 1'b0) begin
            if (hs_cnt == 0) hs_first = int'(pix_x_d);
            hs_cnt++;
         end
         if (pix_x_d == 10'd799 && line_valid) begin
            chk("hsync_width", 64'(hs_cnt), 64'(96));
            chk("hsync_start", 64'(hs_first), 64'(656));
         end
      end
      // exactly one refresh pulse per complete small frame
      if (frame_tick_s) ft_cnt++;
      if (p_tick_s && pix_x_s == 10'(S_HT - 1) && pix_y_s == 10'(S_VT - 1)) begin
         if (frame_valid) chk("frame_tick_per_frame", 64'(ft_cnt), 64'(1));
         frame_valid = 1'b1;
         ft_cnt      = 0;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         if (!reset) k++;
         @(negedge clk);
         sample();
      end
   endtask

   task automatic do_reset(input int n);
      logic [24:0] od;
      @(negedge clk);
      reset = 1'b1;
      #1;
      k           = 0;
      fc_off      = '0;
      line_valid  = 1'b0;
      frame_valid = 1'b0;
      ft_cnt      = 0;
      od = {p_tick_d, hsync_d, vsync_d, video_on_d, frame_tick_d, pix_x_d, pix_y_d};
      chk("reset_async_default", 64'(od), 64'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}));
      chk("reset_async_small_sync", 64'({hsync_s, vsync_s}), 64'(2'b00));
      repeat (n) begin
         @(negedge clk);
         sample();
      end
      reset = 1'b0;
      sample();
      step(1);
      chk("first_ptick_after_release", 64'(p_tick_d), 64'(1));
   endtask

   initial begin
      int n, r;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      do_reset(2);
      $display("step: reset released, running two default lines");
      step(3300);
      $display("step: running several small frames");
      step(6000);
      for (int i = 0; i < 8; i++) begin
         n = $urandom_range(200, 4000);
         r = $urandom_range(1, 4);
         step(n);
         $display("step %0d: ran %0d clks, mid-frame reset for %0d clks", i, n, r);
         do_reset(r);
      end
`ifdef VGA_SYNC_FRAME_CNT_EN
      step(500);
      @(negedge clk);
      force dut_s.frame_cnt_reg = 16'hFFFE;
      #1;
      release dut_s.frame_cnt_reg;
      fc_off = 16'hFFFE - 16'((k / S_D) / (S_HT * S_VT));
      $display("step: small frame counter preloaded to 0xFFFE, running 3 frames");
      step(3 * S_D * S_HT * S_VT);
      chk("frame_cnt_wrapped", 64'(frame_cnt_s < 16'hFFFE), 64'(1));
`endif
      $display("step: long run");
      step(25000);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
